wm_status_panel: RTL and testbench

WM_STATUS_PANEL -- requirements
Module: wm_status_panel

---
 rtl/wm_pkg.sv | 49 ++++
 rtl/wm_tick_counter.sv | 23 ++
 rtl/wm_status_panel.sv | 175 +++++++++++++++++
 tb/tb_wm_status_panel.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared washing-machine state codes, buzzer FSM states and decode helpers.
package wm_pkg;

    typedef enum logic [3:0] {
        StOff     = 4'b0000,
        StIdle    = 4'b0001,
        StFill    = 4'b0010,
        StWash    = 4'b0011,
        StDrain   = 4'b0100,
        StRinse   = 4'b0101,
        StSpin    = 4'b0110,
        StDone    = 4'b0111,
        StStandby = 4'b1000,
        StPaused  = 4'b1001,
        StError   = 4'b1010
    } wm_state_e;

    typedef enum logic [1:0] {
        B_IDLE,
        B_ON,
        B_OFF,
        B_ALARM
    } beep_state_e;

    // Unassigned codes fold onto ERROR.
    function automatic wm_state_e decode_state(logic [3:0] code);
        return (code > 4'(StError)) ? StError : wm_state_e'(code);
    endfunction

    function automatic logic is_run_phase(wm_state_e s);
        return (s inside {StFill, StWash, StDrain, StRinse, StSpin, StDone});
    endfunction

    function automatic logic [5:0] phase_onehot(wm_state_e s);
        logic [5:0] oh;
        oh = '0;
        case (s)
            StFill:  oh = 6'b000001;
            StWash:  oh = 6'b000010;
            StDrain: oh = 6'b000100;
            StRinse: oh = 6'b001000;
            StSpin:  oh = 6'b010000;
            StDone:  oh = 6'b100000;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/wm_tick_counter.sv
// Generic up-counter with synchronous clear, enable, and saturate-or-wrap behaviour.
module wm_tick_counter #(
    parameter int unsigned Width    = 8,
    parameter bit          Saturate = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [Width-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !(Saturate && (&count))) begin
            count <= count + Width'(1);
        end
    end

endmodule

// File: rtl/wm_status_panel.sv
// Front-panel status block: phase lamps, elapsed-time and cycle counters, error blink
// and end-of-cycle / alarm buzzer, all registered from the controller state.
module wm_status_panel
    import wm_pkg::*;
#(
    parameter int unsigned BEEP_TICKS  = 2,
    parameter int unsigned BEEP_COUNT  = 3,
    parameter int unsigned BLINK_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] crnt_state,
    input  logic       door_locked,
    input  logic [1:0] drn_count,
    input  logic       timer_done,
    output logic [5:0] phase_led,
    output logic       lock_led,
    output logic       pause_led,
    output logic       err_led,
    output logic       buzzer,
    output logic [1:0] rinse_disp,
    output logic [7:0] elapsed,
    output logic [7:0] cycles_done
);

    localparam int unsigned BeepW    = $clog2(BEEP_TICKS + 1);
    localparam int unsigned BeepCntW = $clog2(BEEP_COUNT + 1);
    localparam int unsigned BlinkW   = $clog2(BLINK_TICKS + 1);

    wm_state_e   st, prev_q, last_phase_q;
    beep_state_e b_state_q;
    logic        primed_q;
    logic        in_run, in_err, in_pause, done_entry, err_entry;
    logic        elapsed_clr, elapsed_en;
    logic        beep_end, beep_clr, blink_end, blink_clr;
    logic [BeepW-1:0]    beep_cnt;
    logic [BeepCntW-1:0] beeps_q;
    logic [BlinkW-1:0]   blink_cnt;
    logic        unused_timer_done;

    assign unused_timer_done = timer_done;

    assign st         = decode_state(crnt_state);
    assign in_run     = is_run_phase(st);
    assign in_err     = (st == StError);
    assign in_pause   = (st == StPaused);
    // primed_q masks a DONE that is already present when reset releases.
    assign done_entry = primed_q && (st == StDone) && (prev_q != StDone);
    assign err_entry  = in_err && (prev_q != StError);

    // A phase change wins over a coincident tick.
    assign elapsed_clr = in_run ? (st != last_phase_q) : !in_pause;
    assign elapsed_en  = in_run && tick;

    assign beep_end  = tick && (beep_cnt == BeepW'(BEEP_TICKS - 1));
    assign beep_clr  = !(b_state_q inside {B_ON, B_OFF}) || beep_end;
    assign blink_end = in_err && tick && (blink_cnt == BlinkW'(BLINK_TICKS - 1));
    assign blink_clr = !in_err || err_entry || blink_end;

    wm_tick_counter #(.Width(8), .Saturate(1'b1)) u_elapsed (
        .clk   (clk),
        .rst   (rst),
        .clr   (elapsed_clr),
        .en    (elapsed_en),
        .count (elapsed)
    );

    wm_tick_counter #(.Width(BeepW), .Saturate(1'b0)) u_beep_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (beep_clr),
        .en    (tick),
        .count (beep_cnt)
    );

    wm_tick_counter #(.Width(BlinkW), .Saturate(1'b0)) u_blink_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (blink_clr),
        .en    (tick),
        .count (blink_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q       <= StOff;
            primed_q     <= 1'b0;
            last_phase_q <= StOff;
            phase_led    <= '0;
            lock_led     <= 1'b0;
            pause_led    <= 1'b0;
            rinse_disp   <= '0;
            err_led      <= 1'b0;
            cycles_done  <= '0;
        end else begin
            prev_q     <= st;
            primed_q   <= 1'b1;
            lock_led   <= door_locked;
            pause_led  <= in_pause;
            rinse_disp <= drn_count;
            if (in_run) begin
                last_phase_q <= st;
            end else if (!in_pause) begin
                last_phase_q <= StOff;
            end
            if (in_run) begin
                phase_led <= phase_onehot(st);
            end else if (in_pause) begin
                phase_led <= phase_onehot(last_phase_q);
            end else begin
                phase_led <= '0;
            end
            if (!in_err) begin
                err_led <= 1'b0;
            end else if (err_entry) begin
                err_led <= 1'b1;
            end else if (blink_end) begin
                err_led <= ~err_led;
            end
            if (done_entry) begin
                cycles_done <= cycles_done + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_state_q <= B_IDLE;
            buzzer    <= 1'b0;
            beeps_q   <= '0;
        end else if (in_err) begin
            b_state_q <= B_ALARM;
            buzzer    <= 1'b1;
        end else begin
            case (b_state_q)
                B_IDLE: begin
                    if (done_entry) begin
                        b_state_q <= B_ON;
                        buzzer    <= 1'b1;
                        beeps_q   <= '0;
                    end
                end
                B_ON: begin
                    if (st != StDone) begin
                        b_state_q <= B_IDLE;
                        buzzer    <= 1'b0;
                    end else if (beep_end) begin
                        b_state_q <= B_OFF;
                        buzzer    <= 1'b0;
                        beeps_q   <= beeps_q + BeepCntW'(1);
                    end
                end
                B_OFF: begin
                    if (st != StDone) begin
                        b_state_q <= B_IDLE;
                        buzzer    <= 1'b0;
                    end else if (beep_end) begin
                        if (beeps_q == BeepCntW'(BEEP_COUNT)) begin
                            b_state_q <= B_IDLE;
                        end else begin
                            b_state_q <= B_ON;
                            buzzer    <= 1'b1;
                        end
                    end
                end
                default: begin
                    b_state_q <= B_IDLE;
                    buzzer    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wm_status_panel.sv
// Scoreboard bench for wm_status_panel: a behavioural model predicts every output each cycle.
module tb_wm_status_panel;

    localparam int BT = 2;
    localparam int BC = 3;
    localparam int BL = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] crnt_state = 4'd0;
    logic       door_locked = 1'b0;
    logic [1:0] drn_count = 2'd0;
    logic       timer_done = 1'b0;
    logic [5:0] phase_led;
    logic       lock_led, pause_led, err_led, buzzer;
    logic [1:0] rinse_disp;
    logic [7:0] elapsed, cycles_done;

    always #5 clk = ~clk;

    wm_status_panel #(.BEEP_TICKS(BT), .BEEP_COUNT(BC), .BLINK_TICKS(BL)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .crnt_state  (crnt_state),
        .door_locked (door_locked),
        .drn_count   (drn_count),
        .timer_done  (timer_done),
        .phase_led   (phase_led),
        .lock_led    (lock_led),
        .pause_led   (pause_led),
        .err_led     (err_led),
        .buzzer      (buzzer),
        .rinse_disp  (rinse_disp),
        .elapsed     (elapsed),
        .cycles_done (cycles_done)
    );

    typedef struct {
        logic [5:0] ph;
        logic       lk, pz, er, bz;
        logic [1:0] rd;
        logic [7:0] el, cy;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    int m_prev, m_primed, m_last, m_el, m_cy, m_err, m_bl, m_mode, m_bt, m_beeps, m_buz;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_primed = 0; m_last = 0; m_el = 0; m_cy = 0;
        m_err = 0; m_bl = 0; m_mode = 0; m_bt = 0; m_beeps = 0; m_buz = 0;
    endtask

    task automatic model_step(input int s_raw, input bit t, input bit lk, input int rd,
                              output exp_t e);
        int s;
        bit run, entry;
        s = (s_raw > 10) ? 10 : s_raw;
        run = (s >= 2) && (s <= 7);
        entry = (m_primed != 0) && (s == 7) && (m_prev != 7);
        if (run) e.ph = 6'(1 << (s - 2));
        else if (s == 9 && m_last != 0) e.ph = 6'(1 << (m_last - 2));
        else e.ph = 6'd0;
        if (run) begin
            if (s != m_last) begin m_el = 0; m_last = s; end
            else if (t && m_el < 255) m_el++;
        end else if (s != 9) begin
            m_el = 0; m_last = 0;
        end
        if (entry) m_cy = (m_cy + 1) % 256;
        if (s == 10) begin
            if (m_prev != 10) begin m_err = 1; m_bl = 0; end
            else if (t) begin
                m_bl++;
                if (m_bl == BL) begin m_err = 1 - m_err; m_bl = 0; end
            end
        end else begin
            m_err = 0; m_bl = 0;
        end
        if (s == 10) begin
            m_mode = 3; m_buz = 1;
        end else if (m_mode == 3) begin
            m_mode = 0; m_buz = 0;
        end else if (m_mode == 0) begin
            if (entry) begin m_mode = 1; m_bt = 0; m_beeps = 0; m_buz = 1; end
        end else if (s != 7) begin
            m_mode = 0; m_buz = 0;
        end else if (t) begin
            m_bt++;
            if (m_bt == BT) begin
                m_bt = 0;
                if (m_mode == 1) begin m_mode = 2; m_beeps++; m_buz = 0; end
                else if (m_beeps == BC) m_mode = 0;
                else begin m_mode = 1; m_buz = 1; end
            end
        end
        m_prev = s;
        m_primed = 1;
        e.lk = lk; e.pz = (s == 9); e.er = m_err[0]; e.bz = m_buz[0];
        e.rd = 2'(rd); e.el = 8'(m_el); e.cy = 8'(m_cy);
    endtask

    // Entered and left at a falling clock edge.
    task automatic cycle(input int s, input bit t);
        exp_t e, got;
        crnt_state  = 4'(s);
        tick        = t;
        door_locked = 1'($urandom_range(0, 1));
        drn_count   = 2'($urandom_range(0, 3));
        timer_done  = 1'($urandom_range(0, 1));
        model_step(s, t, door_locked, int'(drn_count), e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_val("phase_led", phase_led, got.ph);
        check_val("lock_led", lock_led, got.lk);
        check_val("pause_led", pause_led, got.pz);
        check_val("err_led", err_led, got.er);
        check_val("buzzer", buzzer, got.bz);
        check_val("rinse_disp", rinse_disp, got.rd);
        check_val("elapsed", elapsed, got.el);
        check_val("cycles_done", cycles_done, got.cy);
        @(negedge clk);
    endtask

    task automatic ticks(input int s, input int n);
        repeat (n) begin
            cycle(s, 1'b0);
            cycle(s, 1'b1);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_phase"}, phase_led, 0);
        check_val({tag, "_lock"}, lock_led, 0);
        check_val({tag, "_pause"}, pause_led, 0);
        check_val({tag, "_err"}, err_led, 0);
        check_val({tag, "_buzz"}, buzzer, 0);
        check_val({tag, "_rinse"}, rinse_disp, 0);
        check_val({tag, "_elapsed"}, elapsed, 0);
        check_val({tag, "_cycles"}, cycles_done, 0);
    endtask

    // Called at a falling edge; asserts reset between clock edges.
    task automatic reset_pulse();
        #2 rst = 1'b0;
        #1 check_zero("rst_async");
        sb_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach the end, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int hi, rises, last_bz;
        model_reset();
        #1 check_zero("por");
        @(negedge clk);
        rst = 1'b1;

        // Fill for 5 ticks, then WASH with a coincident tick.
        cycle(1, 1'b0);
        cycle(2, 1'b0);
        check_val("fill_led", phase_led, 6'b000001);
        ticks(2, 5);
        check_val("fill_el5", elapsed, 5);
        cycle(3, 1'b1);
        check_val("wash_led", phase_led, 6'b000010);
        check_val("wash_el0", elapsed, 0);

        // Pause and resume keeps elapsed.
        ticks(3, 3);
        check_val("wash_el3", elapsed, 3);
        cycle(9, 1'b0);
        check_val("pause_on", pause_led, 1);
        check_val("pause_led", phase_led, 6'b000010);
        ticks(9, 4);
        check_val("pause_hold", elapsed, 3);
        cycle(3, 1'b0);
        check_val("pause_off", pause_led, 0);
        ticks(3, 2);
        check_val("resume_el5", elapsed, 5);

        // End-of-cycle beep pattern.
        cycle(6, 1'b0);
        ticks(6, 2);
        check_val("cyc_before", cycles_done, 0);
        last_bz = 0; hi = 0; rises = 0;
        cycle(7, 1'b0);
        check_val("cyc_after", cycles_done, 1);
        hi += buzzer; if (buzzer && !last_bz) rises++; last_bz = buzzer;
        repeat (14) begin
            cycle(7, 1'b0);
            hi += buzzer; if (buzzer && !last_bz) rises++; last_bz = buzzer;
            cycle(7, 1'b1);
            hi += buzzer; if (buzzer && !last_bz) rises++; last_bz = buzzer;
        end
        check_val("beep_pulses", rises, 3);
        check_val("beep_on_cycles", hi, 12);
        check_val("beep_quiet", buzzer, 0);

        // DONE left after one tick aborts the pattern.
        reset_pulse();
        cycle(1, 1'b0);
        cycle(7, 1'b0);
        check_val("abort_bz_on", buzzer, 1);
        cycle(7, 1'b1);
        cycle(1, 1'b0);
        check_val("abort_bz_off", buzzer, 0);
        check_val("abort_cycles", cycles_done, 1);

        // ERROR: continuous alarm and blinking lamp.
        cycle(3, 1'b0);
        ticks(3, 2);
        cycle(10, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check_val("err_blink", err_led, (i % 2 == 0) ? 1 : 0);
            check_val("err_alarm", buzzer, 1);
            cycle(10, 1'b0);
            cycle(10, 1'b1);
        end
        cycle(1, 1'b0);
        check_val("err_exit_led", err_led, 0);
        check_val("err_exit_bz", buzzer, 0);
        check_val("err_exit_el", elapsed, 0);

        // Elapsed saturates.
        cycle(2, 1'b0);
        repeat (258) cycle(2, 1'b1);
        check_val("el_saturate", elapsed, 255);

        // Illegal code is ERROR.
        cycle(15, 1'b0);
        check_val("code15_err", err_led, 1);
        check_val("code15_bz", buzzer, 1);
        check_val("code15_ph", phase_led, 0);

        // cycles_done wraps after 256 entries.
        reset_pulse();
        for (int i = 0; i < 256; i++) begin
            cycle(1, 1'b0);
            cycle(7, 1'b0);
            if (i == 254) check_val("cyc_255", cycles_done, 255);
        end
        check_val("cyc_wrap", cycles_done, 0);

        // Reset mid-beep with DONE held: no new pattern.
        cycle(1, 1'b0);
        cycle(7, 1'b0);
        cycle(7, 1'b1);
        check_val("midbeep_bz", buzzer, 1);
        reset_pulse();
        hi = 0;
        repeat (8) begin
            cycle(7, 1'b0);
            hi += buzzer;
            cycle(7, 1'b1);
            hi += buzzer;
        end
        check_val("no_rebeep", hi, 0);
        check_val("no_recount", cycles_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
